// File: rtl/axi_arb_pkg.sv
// AXI4-Lite 2:1 arbiter shared types.
// State, owner encoding and channel widths.
package axi_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int PROT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_REQ,
    S_WR_RESP
  } state_e;

  typedef enum logic [1:0] {
    OWN_M0   = 2'd0,
    OWN_M1   = 2'd1,
    OWN_NONE = 2'd2
  } owner_e;

  function automatic logic [1:0] owner_oh(owner_e o);
    unique case (o)
      OWN_M0:  return 2'b01;
      OWN_M1:  return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/axi_lite_arbiter_rr_pick2.sv
// Two-way request picker: round-robin on last owner,
// or master 0 always wins a tie when FIXED_PRIO is set.
module rr_pick2
  import axi_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic [1:0] req_i,
  input  owner_e     last_owner_i,
  output logic [1:0] win_o
);

  always_comb begin
    win_o = req_i;
    if (req_i == 2'b11) begin
      if (FIXED_PRIO != 0 || last_owner_i != OWN_M0)
        win_o = 2'b01;
      else
        win_o = 2'b10;
    end
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Two-master to one-slave AXI4-Lite arbiter.
// One whole read or write owns the slave port until its response.
module axi_lite_arbiter
  import axi_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_ARdata,
  input  logic [ADDR_W-1:0] m0_AWdata,
  input  logic [DATA_W-1:0] m0_Wdata,
  input  logic [STRB_W-1:0] m0_Wstrb,
  input  logic [PROT_W-1:0] m0_ARprot,
  input  logic [PROT_W-1:0] m0_AWprot,
  input  logic              m0_ARvalid,
  input  logic              m0_AWvalid,
  input  logic              m0_Wvalid,
  input  logic              m0_RReady,
  input  logic              m0_Bready,
  output logic              m0_ARready,
  output logic              m0_AWready,
  output logic              m0_Wready,
  output logic              m0_Rvalid,
  output logic              m0_Bvalid,
  output logic [DATA_W-1:0] m0_Rdata,
  input  logic [ADDR_W-1:0] m1_ARdata,
  input  logic [ADDR_W-1:0] m1_AWdata,
  input  logic [DATA_W-1:0] m1_Wdata,
  input  logic [STRB_W-1:0] m1_Wstrb,
  input  logic [PROT_W-1:0] m1_ARprot,
  input  logic [PROT_W-1:0] m1_AWprot,
  input  logic              m1_ARvalid,
  input  logic              m1_AWvalid,
  input  logic              m1_Wvalid,
  input  logic              m1_RReady,
  input  logic              m1_Bready,
  output logic              m1_ARready,
  output logic              m1_AWready,
  output logic              m1_Wready,
  output logic              m1_Rvalid,
  output logic              m1_Bvalid,
  output logic [DATA_W-1:0] m1_Rdata,
  output logic [ADDR_W-1:0] s_ARdata,
  output logic [ADDR_W-1:0] s_AWdata,
  output logic [DATA_W-1:0] s_Wdata,
  output logic [STRB_W-1:0] s_Wstrb,
  output logic [PROT_W-1:0] s_ARprot,
  output logic [PROT_W-1:0] s_AWprot,
  output logic              s_ARvalid,
  output logic              s_AWvalid,
  output logic              s_Wvalid,
  output logic              s_RReady,
  output logic              s_Bready,
  input  logic              s_ARready,
  input  logic              s_AWready,
  input  logic              s_Wready,
  input  logic              s_Rvalid,
  input  logic              s_Bvalid,
  input  logic [DATA_W-1:0] s_Rdata,
  output logic [1:0]        grant,
  output logic              busy
);

  state_e state_q;
  owner_e owner_q;
  owner_e last_q;
  logic   aw_done_q;
  logic   w_done_q;

  logic [1:0] req;
  logic [1:0] win;

  assign req = {m1_ARvalid | m1_AWvalid,
                m0_ARvalid | m0_AWvalid};

  rr_pick2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_pick (
    .req_i       (req),
    .last_owner_i(last_q),
    .win_o       (win)
  );

  logic              ar_v, aw_v, w_v, r_rdy, b_rdy;
  logic [ADDR_W-1:0] ar_a, aw_a;
  logic [DATA_W-1:0] w_d;
  logic [STRB_W-1:0] w_s;
  logic [PROT_W-1:0] ar_p, aw_p;

  // Owner mux; everything reads as zero with no owner.
  always_comb begin
    ar_v  = 1'b0;
    aw_v  = 1'b0;
    w_v   = 1'b0;
    r_rdy = 1'b0;
    b_rdy = 1'b0;
    ar_a  = '0;
    aw_a  = '0;
    w_d   = '0;
    w_s   = '0;
    ar_p  = '0;
    aw_p  = '0;
    unique case (owner_q)
      OWN_M0: begin
        ar_v  = m0_ARvalid;
        aw_v  = m0_AWvalid;
        w_v   = m0_Wvalid;
        r_rdy = m0_RReady;
        b_rdy = m0_Bready;
        ar_a  = m0_ARdata;
        aw_a  = m0_AWdata;
        w_d   = m0_Wdata;
        w_s   = m0_Wstrb;
        ar_p  = m0_ARprot;
        aw_p  = m0_AWprot;
      end
      OWN_M1: begin
        ar_v  = m1_ARvalid;
        aw_v  = m1_AWvalid;
        w_v   = m1_Wvalid;
        r_rdy = m1_RReady;
        b_rdy = m1_Bready;
        ar_a  = m1_ARdata;
        aw_a  = m1_AWdata;
        w_d   = m1_Wdata;
        w_s   = m1_Wstrb;
        ar_p  = m1_ARprot;
        aw_p  = m1_AWprot;
      end
      default: ;
    endcase
  end

  logic in_ra, in_rd, in_wq, in_wr;
  assign in_ra = (state_q == S_RD_ADDR);
  assign in_rd = (state_q == S_RD_DATA);
  assign in_wq = (state_q == S_WR_REQ);
  assign in_wr = (state_q == S_WR_RESP);

  assign s_ARdata  = ar_a;
  assign s_AWdata  = aw_a;
  assign s_Wdata   = w_d;
  assign s_Wstrb   = w_s;
  assign s_ARprot  = ar_p;
  assign s_AWprot  = aw_p;
  assign s_ARvalid = in_ra & ar_v;
  assign s_AWvalid = in_wq & aw_v & ~aw_done_q;
  assign s_Wvalid  = in_wq & w_v & ~w_done_q;
  assign s_RReady  = in_rd & r_rdy;
  assign s_Bready  = in_wr & b_rdy;

  logic ar_rdy, aw_rdy, w_rdy, r_v, b_v;
  assign ar_rdy = in_ra & s_ARready;
  assign aw_rdy = in_wq & ~aw_done_q & s_AWready;
  assign w_rdy  = in_wq & ~w_done_q & s_Wready;
  assign r_v    = in_rd & s_Rvalid;
  assign b_v    = in_wr & s_Bvalid;

  logic sel0, sel1;
  assign sel0 = (owner_q == OWN_M0);
  assign sel1 = (owner_q == OWN_M1);

  assign m0_ARready = sel0 & ar_rdy;
  assign m0_AWready = sel0 & aw_rdy;
  assign m0_Wready  = sel0 & w_rdy;
  assign m0_Rvalid  = sel0 & r_v;
  assign m0_Bvalid  = sel0 & b_v;
  assign m0_Rdata   = (sel0 & in_rd) ? s_Rdata : '0;
  assign m1_ARready = sel1 & ar_rdy;
  assign m1_AWready = sel1 & aw_rdy;
  assign m1_Wready  = sel1 & w_rdy;
  assign m1_Rvalid  = sel1 & r_v;
  assign m1_Bvalid  = sel1 & b_v;
  assign m1_Rdata   = (sel1 & in_rd) ? s_Rdata : '0;

  assign grant = owner_oh(owner_q);
  assign busy  = (state_q != S_IDLE);

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  assign ar_hs = s_ARvalid & s_ARready;
  assign r_hs  = in_rd & s_Rvalid & r_rdy;
  assign aw_hs = s_AWvalid & s_AWready;
  assign w_hs  = s_Wvalid & s_Wready;
  assign b_hs  = in_wr & s_Bvalid & b_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_NONE;
      last_q    <= OWN_M1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (win != 2'b00) begin
            owner_q <= win[0] ? OWN_M0 : OWN_M1;
            // Read wins over write from the same master.
            if (win[0] ? m0_ARvalid : m1_ARvalid)
              state_q <= S_RD_ADDR;
            else
              state_q <= S_WR_REQ;
          end
        end
        S_RD_ADDR: begin
          if (ar_hs) state_q <= S_RD_DATA;
        end
        S_RD_DATA: begin
          if (r_hs) begin
            state_q <= S_IDLE;
            last_q  <= owner_q;
            owner_q <= OWN_NONE;
          end
        end
        S_WR_REQ: begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs)  w_done_q  <= 1'b1;
          if ((aw_done_q | aw_hs) & (w_done_q | w_hs))
            state_q <= S_WR_RESP;
        end
        S_WR_RESP: begin
          if (b_hs) begin
            state_q   <= S_IDLE;
            last_q    <= owner_q;
            owner_q   <= OWN_NONE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_lite_arbiter.md
# axi_lite_arbiter

Two-master to one-slave AXI4-Lite arbiter that shares the single external memory port between the mriscvcore memory interface (master 0) and a secondary requester such as a debug/DMA engine (master 1). It grants one complete transaction at a time, either a read (AR→R) or a write (AW+W→B). The grant is locked until the response handshake completes, and masters are served round-robin. It sits between the core's AXI4-Lite pins and the system bus.

## Interface
- FIXED_PRIO, default 0: 0 = round-robin; 1 = master 0 always wins ties.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mX_ARdata, mX_AWdata  in  32  read/write address from master X (X = 0, 1).
- mX_Wdata  in  32  write data. mX_Wstrb  in  4  byte strobes.
- mX_ARprot, mX_AWprot  in  3  protection bits, passed through.
- mX_ARvalid, mX_AWvalid, mX_Wvalid, mX_RReady, mX_Bready  in  1  master handshake signals.
- mX_ARready, mX_AWready, mX_Wready, mX_Rvalid, mX_Bvalid  out  1  handshake signals returned to master X.
- mX_Rdata  out  32  read data to master X.
- s_ARdata, s_AWdata, s_Wdata  out  32. s_Wstrb  out  4. s_ARprot, s_AWprot  out  3.
- s_ARvalid, s_AWvalid, s_Wvalid, s_RReady, s_Bready  out  1  slave-side handshake signals.
- s_ARready, s_AWready, s_Wready, s_Rvalid, s_Bvalid  in  1. s_Rdata  in  32.
- grant  out  2  one-hot owner: bit0 = m0, bit1 = m1; 00 when idle.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP. Registers: state, owner, last_owner, aw_done, w_done.
- IDLE: a master requests when ARvalid or AWvalid is high. A read has priority over a write from the same master.
- Winner selection:
  - If both masters request and FIXED_PRIO=0, the master that is not last_owner wins.
  - If both request and FIXED_PRIO=1, m0 wins.
  - A single requester always wins.
- On grant, register the owner and go to RD_ADDR (read) or WR_REQ (write).
- RD_ADDR: owner's AR channel routed to the slave. On s_ARvalid & s_ARready, go to RD_DATA.
- RD_DATA: slave's R channel routed to the owner. On s_Rvalid & s_RReady, go to IDLE and set last_owner ← owner.
- WR_REQ: owner's AW and W channels routed to the slave independently.
  - Set aw_done on the AW handshake and w_done on the W handshake.
  - After a channel's flag is set, its s_ valid and mX_ ready are forced to 0.
  - When both flags are set (either order, or in the same cycle), go to WR_RESP.
- WR_RESP: B channel routed to the owner. On the handshake, go to IDLE, clear both flags, set last_owner.
- Routing is combinational from the registered state/owner. Address, data, strb and prot are muxed by owner.
- Non-owner master: all of its ready and valid outputs are 0; its Rdata is 0.
- In IDLE, every s_ valid/ready output is 0 and every mX_ ready/valid output is 0.
- If the owner deasserts a valid before its handshake (protocol violation), the arbiter holds its state. It never re-arbitrates mid-transaction.

## Timing
- Reset values: state=IDLE, owner=none, last_owner=m1 (so m0 wins the first tie), aw_done=w_done=0.
  - All outputs 0 after reset, including grant=00 and busy=0.
- Arbitration latency is 1 cycle: a request visible in IDLE at edge N is forwarded to the slave from cycle N+1.
- Minimum read occupancy is 3 cycles: IDLE, then RD_ADDR with ready in the same cycle, then RD_DATA with Rvalid in the same cycle.
- Minimum write occupancy is 3 cycles: IDLE, WR_REQ, WR_RESP.
- A new request pending when the arbiter returns to IDLE is granted on the next edge. No idle bubble beyond the IDLE cycle itself.
- Reset asserted mid-transaction: state returns to IDLE on the next edge and all s_ valids drop. Slave-side recovery is outside this block.
- Simultaneous AW and W handshakes in the same cycle: WR_REQ → WR_RESP directly.

## Structure
- Package axi_arb_pkg holds the state enum (5 states), owner encoding (M0, M1, NONE) and the AXI-Lite width constants (ADDR_W=32, DATA_W=32, STRB_W=4, PROT_W=3).
- Sub-module rr_pick2: combinational 2-way picker. Inputs: req[1:0], last_owner, FIXED_PRIO. Output: one-hot winner.
- All channel muxing stays in the top module.

## Test plan
- Single read by m0 to 0x0000_1000; slave ARready at cycle 1, Rvalid with 0xDEAD_BEEF at cycle 3 → m0_Rdata=0xDEAD_BEEF with m0_Rvalid; grant=01 through the transaction; m1 sees all zeros.
- m0 and m1 request reads in the same cycle, FIXED_PRIO=0 → m0 served first, m1 next; repeated simultaneous requests alternate m0, m1, m0. With FIXED_PRIO=1, m0 is served every time.
- m1 write: AW at 0x20 handshake first, W=0x1234_5678 with Wstrb=0011 two cycles later → WR_RESP is entered only after the W handshake; s_Wstrb=0011; m1_Bvalid follows s_Bvalid.
- AW and W handshakes in the same cycle → WR_RESP on the next cycle; a read request from m0 arriving mid-write waits until the B handshake plus one cycle.
- Slave stalls Rvalid for 10 cycles → state stays RD_DATA, busy=1, m1's pending request is not granted.
- rst asserted during WR_REQ → next cycle state=IDLE, all outputs 0, grant=00; the next request is arbitrated with m0 winning ties.
